// File: rtl/hazard_stall_controller.sv
// Pipeline hazard stall/flush controller with multiplier start/busy/done sequencer.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
    parameter int MULT_LATENCY = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [4:0]       RS1__IF_ID,
    input  logic [4:0]       RS2__IF_ID,
    input  logic [4:0]       RD__ID_EX,
    input  logic             mem_read_ID_EX,
    input  logic [4:0]       RD__EX_MEM,
    input  logic             mem_2_reg_EX_MEM,
    input  logic             mult_ID_EX,
    input  logic             branch_taken_EX,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_hold,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_bubble,
    output logic             mult_start,
    output logic             mult_busy,
    output logic             mult_done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hold;
    logic       lu_a, lu_b;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (mult_ID_EX) begin
                state_d = BUSY;
                cnt_d   = 4'(MULT_LATENCY - 2);
            end
            BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                  else state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign hold = ((state_q == IDLE) && mult_ID_EX) || ((state_q == BUSY) && (cnt_q != 4'd0));

    // Loads forward only from MEM/WB, so a consumer in ID waits for both EX and MEM.
    assign lu_a = mem_read_ID_EX && (RD__ID_EX != 5'd0) &&
                  ((RD__ID_EX == RS1__IF_ID) || (RD__ID_EX == RS2__IF_ID));
    assign lu_b = mem_2_reg_EX_MEM && (RD__EX_MEM != 5'd0) &&
                  ((RD__EX_MEM == RS1__IF_ID) || (RD__EX_MEM == RS2__IF_ID));

    always_comb begin
        pc_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_hold    = 1'b0;
        ID_EX_bubble  = 1'b0;
        EX_MEM_bubble = 1'b0;
        mult_start    = (state_q == IDLE) && mult_ID_EX;
        mult_busy     = hold;
        mult_done     = (state_q == BUSY) && (cnt_q == 4'd0);
        if (hold) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_hold    = 1'b1;
            EX_MEM_bubble = 1'b1;
        end else if (branch_taken_EX && !mult_ID_EX) begin
            // A multiply in EX overrides a simultaneously asserted branch.
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else if (lu_a || lu_b) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed plus random stimulus for hazard_stall_controller, checked against a
// cycle-stamp reference model of the multiply window and the hazard priority rules.
module tb_hazard_stall_controller;

    localparam int L     = 4;
    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       arst;
    logic [4:0] rs1, rs2, rdx, rdm;
    logic       mr, m2r, mul, br;
    logic       pc_write, IF_ID_write, IF_ID_flush, ID_EX_hold, ID_EX_bubble;
    logic       EX_MEM_bubble, mult_start, mult_busy, mult_done;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    hazard_stall_controller #(.MULT_LATENCY(L), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst(arst),
        .RS1__IF_ID(rs1), .RS2__IF_ID(rs2), .RD__ID_EX(rdx), .mem_read_ID_EX(mr),
        .RD__EX_MEM(rdm), .mem_2_reg_EX_MEM(m2r), .mult_ID_EX(mul), .branch_taken_EX(br),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_hold(ID_EX_hold), .ID_EX_bubble(ID_EX_bubble), .EX_MEM_bubble(EX_MEM_bubble),
        .mult_start(mult_start), .mult_busy(mult_busy), .mult_done(mult_done)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    logic [8:0] got;
    assign got = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_hold, ID_EX_bubble,
                  EX_MEM_bubble, mult_start, mult_busy, mult_done};

    int errors = 0;
    int checks = 0;

    // Reference model: a multiply occupies cycles start..start+L-1 of the cycle stamp.
    int         cyc = 0;
    bit         m_active = 0;
    int         m_start = 0;
    bit         m_done;
    int         m_stall = 0;
    logic [8:0] exp_v;

    localparam logic [8:0] NORMAL = 9'b110000000;

    task automatic check(input string tag, input logic [8:0] g, input logic [8:0] e);
        checks++;
        assert (g === e) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, g, e);
        end
    endtask

    task automatic model_eval();
        bit hold, start, lu_a, lu_b;
        int el;
        if (!m_active) begin
            start = mul; hold = mul; m_done = 0;
        end else begin
            el = cyc - m_start;
            start = 0; hold = (el < L - 1); m_done = (el == L - 1);
        end
        lu_a = mr  && rdx != 0 && (rdx == rs1 || rdx == rs2);
        lu_b = m2r && rdm != 0 && (rdm == rs1 || rdm == rs2);
        if (hold)              exp_v = {8'b00010101, 1'b0} | {6'b0, start, 2'b0};
        else if (br && !mul)   exp_v = {8'b11101000, m_done};
        else if (lu_a || lu_b) exp_v = {8'b00001000, m_done};
        else                   exp_v = {8'b11000000, m_done};
    endtask

    task automatic model_edge();
        if (!m_active && mul) begin
            m_active = 1; m_start = cyc;
        end else if (m_active && m_done) m_active = 0;
        if (!exp_v[8] && m_stall < (1 << CNT_W) - 1) m_stall++;
        cyc++;
    endtask

    task automatic check_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (stall_cycles === CNT_W'(m_stall)) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, stall_cycles, m_stall);
        end
`endif
    endtask

    // Inputs are driven at the falling edge; outputs sampled 1ns later.
    task automatic step(input string tag, input logic [4:0] a1, a2, ax, input logic amr,
                        input logic [4:0] am, input logic am2r, amul, abr);
        rs1 = a1; rs2 = a2; rdx = ax; mr = amr; rdm = am; m2r = am2r; mul = amul; br = abr;
        #1;
        model_eval();
        check(tag, got, exp_v);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cnt({tag, "_cnt"});
    endtask

    task automatic do_reset(input string tag);
        rs1 = 0; rs2 = 0; rdx = 0; mr = 0; rdm = 0; m2r = 0; mul = 0; br = 0;
        arst = 1'b1;
        #1;
        check(tag, got, NORMAL);
        m_active = 0; m_stall = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        arst = 1'b0;
        check_cnt({tag, "_cnt"});
    endtask

    initial begin
        arst = 1'b0;
        @(negedge clk);
        do_reset("reset");
        cyc = 0;
        // Single multiply entering EX at cycle 10.
        while (cyc < 10) step("idle", 1, 2, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < L; i++) step("mul", 1, 2, 5, 0, 0, 0, 1, 0);
        step("mul_after", 1, 2, 0, 0, 0, 0, 0, 0);
        // Load-use: dependent directly behind load, then one slot later.
        step("lu_a", 3, 7, 3, 1, 0, 0, 0, 0);
        step("lu_b", 3, 7, 0, 0, 3, 1, 0, 0);
        step("lu_clear", 3, 7, 0, 0, 0, 0, 0, 0);
        step("lu_rs2", 9, 3, 3, 1, 0, 0, 0, 0);
        step("lw_x0", 0, 0, 0, 1, 0, 1, 0, 0);
        step("br_over_lu", 3, 7, 3, 1, 0, 0, 0, 1);
        step("mul_over_br", 1, 2, 5, 0, 0, 0, 1, 1);
        for (int i = 1; i < L; i++) step("mul_br", 1, 2, 5, 0, 0, 0, 1, 0);
        // Back-to-back multiplies, then reset while the second is in flight.
        for (int i = 0; i < L; i++) step("mul_b2b0", 1, 2, 5, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) step("mul_b2b1", 1, 2, 6, 0, 0, 0, 1, 0);
        do_reset("reset_mid_mul");
        for (int i = 0; i < L; i++) step("post_abort", 1, 2, 0, 0, 0, 0, 0, 0);
        // Known stall total: 3 hold cycles plus 2 load-use cycles.
        do_reset("reset_cnt");
        for (int i = 0; i < L; i++) step("cnt_mul", 1, 2, 5, 0, 0, 0, 1, 0);
        step("cnt_lu_a", 4, 0, 4, 1, 0, 0, 0, 0);
        step("cnt_lu_b", 4, 0, 0, 0, 4, 1, 0, 0);
        step("cnt_idle", 4, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        assert (m_stall == 5 || errors != 0) else begin
            errors++;
            $error("FAIL model_stall got=%0d exp=5", m_stall);
        end
        // Random traffic over a small register range to provoke matches.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 60) == 0) do_reset("rand_reset");
            else step("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Central stall/flush controller for the 5-stage RISC-V pipeline with the 4-cycle iterative multiplier. Sits beside the forwarding unit. It detects hazards that forwarding cannot resolve and freezes or bubbles the PC, IF/ID and ID/EX registers accordingly:
- load-use, since loads are forwarded only from MEM/WB;
- multi-cycle multiply occupancy of EX;
- taken-branch flushes.

It also sequences the multiplier through a start/busy/done FSM.

## Interface
Parameters:
- MULT_LATENCY, default 4: cycles a multiply occupies EX; legal range 2..16.
- CNT_W, default 32: width of the stall counter (used only with the configuration macro).

Ports (reset is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge.
- arst  in  1  asynchronous active-high reset.
- RS1__IF_ID  in  5  rs1 of the instruction in ID.
- RS2__IF_ID  in  5  rs2 of the instruction in ID.
- RD__ID_EX  in  5  destination of the instruction in EX.
- mem_read_ID_EX  in  1  instruction in EX is a load.
- RD__EX_MEM  in  5  destination of the instruction in MEM.
- mem_2_reg_EX_MEM  in  1  instruction in MEM is a load.
- mult_ID_EX  in  1  instruction in EX is a multiply.
- branch_taken_EX  in  1  branch/jump in EX resolved taken.
- pc_write  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID load enable.
- IF_ID_flush  out  1  clear IF/ID to NOP.
- ID_EX_hold  out  1  freeze ID/EX.
- ID_EX_bubble  out  1  load NOP into ID/EX.
- EX_MEM_bubble  out  1  load NOP into EX/MEM.
- mult_start  out  1  one-cycle start pulse to multiplier.
- mult_busy  out  1  multiply in progress.
- mult_done  out  1  multiplier result valid this cycle.
- stall_cycles  out  CNT_W  stall cycle count (only with HAZARD_PERF_CNT_EN).

## Operation
Multiplier FSM, states IDLE and BUSY, with a 4-bit down-counter `cnt`:
- IDLE & mult_ID_EX:
  - assert mult_start and hold;
  - `cnt` <= MULT_LATENCY-2;
  - go to BUSY.
- BUSY & cnt!=0: assert hold; `cnt` decrements.
- BUSY & cnt==0: assert mult_done; deassert hold; go to IDLE.
- hold = (IDLE & mult_ID_EX) | (BUSY & cnt!=0). While hold is asserted:
  - pc_write=0, IF_ID_write=0, ID_EX_hold=1, EX_MEM_bubble=1;
  - ID_EX_bubble=0 and IF_ID_flush=0.
- mult_busy = hold.
- A multiply immediately behind another starts a new sequence in the cycle after mult_done, with no gap.

Load-use detection, evaluated only when hold=0:
- luA = mem_read_ID_EX & RD__ID_EX!=0 & (RD__ID_EX==RS1__IF_ID | RD__ID_EX==RS2__IF_ID).
- luB = mem_2_reg_EX_MEM & RD__EX_MEM!=0 & (RD__EX_MEM==RS1__IF_ID | RD__EX_MEM==RS2__IF_ID).
- luA|luB: pc_write=0, IF_ID_write=0, ID_EX_bubble=1.
- Net effect: a dependent instruction directly after a load gets 2 bubbles; one instruction later it gets 1 bubble.

Branch handling, when hold=0:
- branch_taken_EX: IF_ID_flush=1, ID_EX_bubble=1, pc_write=1.
- Branch takes priority over load-use.
- branch_taken_EX and mult_ID_EX are mutually exclusive; if both are asserted, the multiply wins and the branch is ignored.

Priority order: hold > branch > load-use > normal. Normal means pc_write=1, IF_ID_write=1, all other outputs 0.

## Timing
- All hazard outputs are combinational from the inputs plus state, and are valid in the same cycle.
- State and `cnt` update on the rising edge of clk.
- The multiply occupies EX for exactly MULT_LATENCY cycles (t..t+MULT_LATENCY-1):
  - mult_start is asserted at t;
  - mult_done is asserted at t+MULT_LATENCY-1.
- Reset (arst=1, asynchronous): state=IDLE, cnt=0, stall_cycles=0.
- With every input at 0 during reset: pc_write=1, IF_ID_write=1, all other outputs 0.
- Reset mid-multiply aborts the sequence; mult_done is never asserted for the aborted op.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles port exists;
  - it increments on every rising edge where pc_write==0 & arst==0;
  - it saturates at 2^CNT_W-1 and does not wrap.
- HAZARD_PERF_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- MUL x5 in EX at cycle 10, MULT_LATENCY=4 -> mult_start@10; hold (pc_write=0, EX_MEM_bubble=1) @10-12; mult_done@13; pc_write=1@13.
- LW x3 in EX, ID reads rs1=x3 -> ID_EX_bubble=1 for 2 consecutive cycles, then pc_write=1.
- LW x0 in EX, ID reads x0 -> no stall, pc_write=1.
- branch_taken_EX=1 while luA=1 -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1.
- Two back-to-back MULs -> mult_done@13 then mult_start@14, no idle gap; arst pulse @12 -> IDLE, no mult_done, outputs return to normal.
- With HAZARD_PERF_CNT_EN: 3-cycle mult hold plus 2-cycle load-use stall -> stall_cycles=5.
